alu_exec: RTL

- Execution unit directly downstream of the ALU reservation station.
- Consumes one station slot's registered outputs: op, operand tags/data, destination tag, destination register.
- While operands are still locked, snoops the common result buses and computes the result; shifts are iterative.
- Broadcasts the result for one cycle on its result bus. The station and sibling units consume that broadcast to unlock dependents.

---
 rtl/alu_exec_pkg.sv | 70 +++++++
 rtl/alu_exec_comb.sv | 32 +++
 rtl/alu_exec.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution unit: widths, the UNLOCKED tag,
// op-code encodings, FSM state encoding and the result-bus snoop helper.
package alu_exec_pkg;

    localparam int WORD_W  = 32;
    localparam int TAG_W   = 4;
    localparam int OP_W    = 4;
    localparam int RADDR_W = 5;
    localparam int SHAMT_W = 5;

    // Tag value meaning "operand data is valid, nothing to wait for".
    localparam logic [TAG_W-1:0] UNLOCKED = '0;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_SLT   = 4'd5;
    localparam logic [OP_W-1:0] OP_SLTU  = 4'd6;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd7;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd8;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd9;
    localparam logic [OP_W-1:0] OP_PASSY = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One operand as tracked by the unit: its lock tag and its data.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] data;
    } operand_t;

    // True for the ops handled by the iterative shifter.
    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Resolve a locked operand from the result buses. The sibling ALU wins
    // over load/store; an already unlocked operand is never compared, so a
    // broadcast that happens to carry tag 0 cannot overwrite valid data.
    function automatic operand_t snoop(
        input operand_t          cur,
        input logic              alu_busy,
        input logic [TAG_W-1:0]  alu_tag,
        input logic [WORD_W-1:0] alu_data,
        input logic              ls_busy,
        input logic [TAG_W-1:0]  ls_tag_in,
        input logic [WORD_W-1:0] ls_data_in
    );
        operand_t res;
        res = cur;
        if (cur.tag != UNLOCKED) begin
            if (!alu_busy && (cur.tag == alu_tag)) begin
                res.tag  = UNLOCKED;
                res.data = alu_data;
            end else if (!ls_busy && (cur.tag == ls_tag_in)) begin
                res.tag  = UNLOCKED;
                res.data = ls_data_in;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_exec_comb.sv
// alu_comb: single-cycle ALU datapath. Shift ops are resolved iteratively by
// the parent; here they only pass x through, which is the correct result for
// a shift amount of zero.
module alu_comb
    import alu_exec_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    output logic [WORD_W-1:0] result
);

    // Select the result of the requested op; unknown op codes give zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:   result = x + y;
            OP_SUB:   result = x - y;
            OP_AND:   result = x & y;
            OP_OR:    result = x | y;
            OP_XOR:   result = x ^ y;
            OP_SLT:   result = {{(WORD_W-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU:  result = {{(WORD_W-1){1'b0}}, (x < y)};
            OP_SLL,
            OP_SRL,
            OP_SRA:   result = x;
            OP_PASSY: result = y;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: ALU execution unit fed by one reservation-station slot. Waits for
// locked operands by snooping the sibling ALU and load/store result buses,
// computes the result (shifts one bit per cycle) and broadcasts it for one
// cycle on its own result bus.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               busy_in,
    input  logic [OP_W-1:0]    op_in,
    input  logic [TAG_W-1:0]   tagx_in,
    input  logic [TAG_W-1:0]   tagy_in,
    input  logic [TAG_W-1:0]   tagw_in,
    input  logic [WORD_W-1:0]  datax_in,
    input  logic [WORD_W-1:0]  datay_in,
    input  logic [RADDR_W-1:0] target_in,
    input  logic               busy_alu_oth,
    input  logic [TAG_W-1:0]   alu_tag_oth,
    input  logic [WORD_W-1:0]  alu_data_oth,
    input  logic               busy_ls,
    input  logic [TAG_W-1:0]   ls_tag,
    input  logic [WORD_W-1:0]  ls_data,
    output logic               issue_ready,
    output logic               busy_out,
    output logic [TAG_W-1:0]   tag_out,
    output logic [WORD_W-1:0]  data_out,
    output logic [RADDR_W-1:0] target_out
);

    state_t state;
    state_t next_state;

    logic [OP_W-1:0]    op_r;
    operand_t           opx_r;
    operand_t           opy_r;
    logic [TAG_W-1:0]   tagw_r;
    logic [RADDR_W-1:0] target_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WORD_W-1:0]  acc_r;

    operand_t           src_x;
    operand_t           src_y;
    operand_t           res_x;
    operand_t           res_y;
    logic [OP_W-1:0]    cur_op;
    logic [TAG_W-1:0]   cur_tagw;
    logic [RADDR_W-1:0] cur_target;
    logic [WORD_W-1:0]  comb_result;
    logic [WORD_W-1:0]  shift_next;
    logic [WORD_W-1:0]  done_data;
    logic [WORD_W-1:0]  bcast_data;
    logic [SHAMT_W-1:0] shamt;
    logic               operands_ready;
    logic               start_shift;

    logic load_issue;
    logic update_operands;
    logic enter_shift;
    logic step_shift;
    logic enter_done;
    logic leave_done;

    // Operands come straight from the slot while idle, from the latches after.
    always_comb begin
        if (state == ST_IDLE) begin
            src_x      = '{tag: tagx_in, data: datax_in};
            src_y      = '{tag: tagy_in, data: datay_in};
            cur_op     = op_in;
            cur_tagw   = tagw_in;
            cur_target = target_in;
        end else begin
            src_x      = opx_r;
            src_y      = opy_r;
            cur_op     = op_r;
            cur_tagw   = tagw_r;
            cur_target = target_r;
        end
    end

    assign res_x = snoop(src_x, busy_alu_oth, alu_tag_oth, alu_data_oth,
                         busy_ls, ls_tag, ls_data);
    assign res_y = snoop(src_y, busy_alu_oth, alu_tag_oth, alu_data_oth,
                         busy_ls, ls_tag, ls_data);

    assign operands_ready = (res_x.tag == UNLOCKED) && (res_y.tag == UNLOCKED);
    assign shamt          = res_y.data[SHAMT_W-1:0];
    assign start_shift    = is_shift(cur_op) && (shamt != '0);

    alu_comb u_alu_comb (
        .op     (cur_op),
        .x      (res_x.data),
        .y      (res_y.data),
        .result (comb_result)
    );

    // One-bit step of the iterative shifter; SRA keeps replicating the sign.
    always_comb begin
        shift_next = acc_r;
        case (op_r)
            OP_SLL:  shift_next = {acc_r[WORD_W-2:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, acc_r[WORD_W-1:1]};
            OP_SRA:  shift_next = {acc_r[WORD_W-1], acc_r[WORD_W-1:1]};
            default: shift_next = acc_r;
        endcase
    end

    // FSM next-state and control strobes; a result heads to DONE once both
    // operands are unlocked and any shift has run its full count.
    always_comb begin
        next_state      = state;
        issue_ready     = 1'b0;
        load_issue      = 1'b0;
        update_operands = 1'b0;
        enter_shift     = 1'b0;
        step_shift      = 1'b0;
        enter_done      = 1'b0;
        leave_done      = 1'b0;
        done_data       = comb_result;
        case (state)
            ST_IDLE: begin
                issue_ready = 1'b1;
                if (busy_in) begin
                    load_issue      = 1'b1;
                    update_operands = 1'b1;
                    if (!operands_ready) begin
                        next_state = ST_WAIT;
                    end else if (start_shift) begin
                        next_state  = ST_SHIFT;
                        enter_shift = 1'b1;
                    end else begin
                        next_state = ST_DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                update_operands = 1'b1;
                if (operands_ready) begin
                    if (start_shift) begin
                        next_state  = ST_SHIFT;
                        enter_shift = 1'b1;
                    end else begin
                        next_state = ST_DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                step_shift = 1'b1;
                done_data  = shift_next;
                if (cnt_r == SHAMT_W'(1)) begin
                    next_state = ST_DONE;
                    enter_done = 1'b1;
                end
            end
            ST_DONE: begin
                leave_done = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign bcast_data = (cur_target == '0) ? '0 : done_data;

    // State register; reset wins over rdy, and rdy low freezes the FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= next_state;
        end
    end

    // Instruction latches, shifter and registered broadcast outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r       <= '0;
            opx_r      <= '0;
            opy_r      <= '0;
            tagw_r     <= UNLOCKED;
            target_r   <= '0;
            cnt_r      <= '0;
            acc_r      <= '0;
            busy_out   <= 1'b1;
            tag_out    <= UNLOCKED;
            data_out   <= '0;
            target_out <= '0;
        end else if (rdy) begin
            if (load_issue) begin
                op_r     <= op_in;
                tagw_r   <= tagw_in;
                target_r <= target_in;
            end
            if (update_operands) begin
                opx_r <= res_x;
                opy_r <= res_y;
            end
            if (enter_shift) begin
                acc_r <= res_x.data;
                cnt_r <= shamt;
            end else if (step_shift) begin
                acc_r <= shift_next;
                cnt_r <= cnt_r - SHAMT_W'(1);
            end
            if (enter_done) begin
                busy_out   <= 1'b0;
                tag_out    <= cur_tagw;
                data_out   <= bcast_data;
                target_out <= cur_target;
            end else if (leave_done) begin
                busy_out <= 1'b1;
            end
        end
    end

endmodule
